// File: rtl/pll_rst_pkg.sv
// Shared types and phase-decode constants for the PLL reset / clock-enable generator.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SOFT      = 3'd4
    } state_t;

    // Phase values at which each enable fires (compared on the low bits shown)
    localparam logic [1:0] CE24_PH = 2'd3;
    localparam logic [2:0] CE12_PH = 3'd7;
    localparam logic [3:0] CE6_PH  = 4'd15;
    localparam logic [3:0] CE6N_PH = 4'd7;

    function automatic logic is_running(input state_t s);
        return (s == RELEASE) || (s == RUN) || (s == SOFT);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchronizer with asynchronous clear, for signals crossing into clk.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Staged video/CPU reset release after stable PLL lock, CPU-only soft reset,
// and 24/12/6 MHz clock enables derived from the 96 MHz PLL clock.
module pll_reset_ce_gen
    import pll_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 4096,
    parameter int unsigned STAGGER_CYCLES     = 256,
    parameter int unsigned SOFT_RST_CYCLES    = 64,
    parameter int unsigned CNT_W              = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic soft_rst_req,
    output logic rst_video,
    output logic rst_cpu,
    output logic ce_24m,
    output logic ce_12m,
    output logic ce_6m,
    output logic ce_6m_n,
    output logic ready,
    output logic lock_lost
);

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             w_locked_s;
    logic             w_soft_s;
    logic             w_running;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_ph;
    logic [3:0]       w_ph_nxt;
    logic             r_lock_lost;
    logic             w_lock_lost_nxt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (locked),
        .o_q   (w_locked_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_soft (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (soft_rst_req),
        .o_q   (w_soft_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_ph        <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ph        <= w_ph_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lock_lost_nxt = r_lock_lost;

        // Loss of lock overrides every other transition, including a pending soft reset
        if ((r_state != WAIT_LOCK) && !w_locked_s) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
            if (is_running(r_state)) begin
                w_lock_lost_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    w_cnt_nxt = '0;
                    if (w_locked_s) begin
                        w_state_nxt = STABLE;
                    end
                end
                STABLE: begin
                    if (r_cnt == LOCK_LAST) begin
                        w_state_nxt = RELEASE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (r_cnt == STAGGER_LAST) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                RUN: begin
                    w_cnt_nxt = '0;
                    if (w_soft_s) begin
                        w_state_nxt = SOFT;
                    end
                end
                SOFT: begin
                    // Counter saturates so the request length can stretch the reset
                    if (r_cnt == SOFT_LAST) begin
                        if (!w_soft_s) begin
                            w_state_nxt = RUN;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Phase restarts at 0 on entry to RELEASE and free-runs while video is out of reset
    always_comb begin
        w_ph_nxt = '0;
        if (is_running(w_state_nxt) && is_running(r_state)) begin
            w_ph_nxt = r_ph + 4'd1;
        end
    end

    assign w_running = is_running(r_state);

    assign rst_video = !w_running;
    assign rst_cpu   = (r_state != RUN);
    assign ready     = (r_state == RUN);
    assign lock_lost = r_lock_lost;

    assign ce_24m  = w_running && (r_ph[1:0] == CE24_PH);
    assign ce_12m  = w_running && (r_ph[2:0] == CE12_PH);
    assign ce_6m   = w_running && (r_ph == CE6_PH);
    assign ce_6m_n = w_running && (r_ph == CE6N_PH);

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Self-checking bench for pll_reset_ce_gen: table vectors, corner-case sequences,
// and randomized lock/soft-reset traffic against a lock-run-length reference model.
module tb_pll_reset_ce_gen;

    localparam int SYNC = 2;
    localparam int LSC  = 16;
    localparam int STG  = 8;
    localparam int SRC  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b0;
    logic soft_rst_req = 1'b0;
    logic rst_video, rst_cpu, ce_24m, ce_12m, ce_6m, ce_6m_n, ready, lock_lost;

    int checks = 0;
    int failures = 0;

    pll_reset_ce_gen #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LSC),
        .STAGGER_CYCLES     (STG),
        .SOFT_RST_CYCLES    (SRC),
        .CNT_W              (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .rst_video    (rst_video),
        .rst_cpu      (rst_cpu),
        .ce_24m       (ce_24m),
        .ce_12m       (ce_12m),
        .ce_6m        (ce_6m),
        .ce_6m_n      (ce_6m_n),
        .ready        (ready),
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    // Reference model: m_n counts consecutive edges that saw the synchronized lock high;
    // video runs once that reaches LSC+1, and all timing derives from the age past that point.
    int m_n;
    bit m_soft;
    int m_soft_start;
    bit m_lost;
    int m_edge = 0;
    bit lq[$];
    bit sq[$];

    function automatic void model_reset();
        m_n = 0;
        m_soft = 1'b0;
        m_soft_start = 0;
        m_lost = 1'b0;
        lq = {};
        sq = {};
        for (int i = 0; i < SYNC; i++) begin
            lq.push_back(1'b0);
            sq.push_back(1'b0);
        end
    endfunction

    function automatic void model_edge(input bit l, input bit s);
        bit ls, ss, prev_rel;
        int age_prev;
        ls = lq.pop_front();
        ss = sq.pop_front();
        lq.push_back(l);
        sq.push_back(s);
        m_edge++;
        prev_rel = (m_n >= LSC + 1);
        age_prev = m_n - (LSC + 1);
        if (!ls) begin
            if (prev_rel) m_lost = 1'b1;
            m_n = 0;
            m_soft = 1'b0;
        end else begin
            m_n++;
            if (m_soft) begin
                if ((m_edge - m_soft_start >= SRC) && !ss) m_soft = 1'b0;
            end else if (prev_rel && age_prev >= STG && ss) begin
                m_soft = 1'b1;
                m_soft_start = m_edge;
            end
        end
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        bit rel;
        int age, ph;
        logic exp_cpu;
        rel = (m_n >= LSC + 1);
        age = rel ? (m_n - (LSC + 1)) : 0;
        ph  = age % 16;
        exp_cpu = !(rel && age >= STG && !m_soft);
        chk("model_rst_video", rst_video, !rel);
        chk("model_rst_cpu", rst_cpu, exp_cpu);
        chk("model_ready", ready, !exp_cpu);
        chk("model_ce_24m", ce_24m, rel && (ph % 4 == 3));
        chk("model_ce_12m", ce_12m, rel && (ph % 8 == 7));
        chk("model_ce_6m", ce_6m, rel && (ph == 15));
        chk("model_ce_6m_n", ce_6m_n, rel && (ph == 7));
        chk("model_lock_lost", lock_lost, m_lost);
    endtask

    task automatic step(input logic l, input logic s);
        locked = l;
        soft_rst_req = s;
        @(posedge clk);
        model_edge(l, s);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        locked = 1'b0;
        soft_rst_req = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int   ncyc;
        logic l;
        logic s;
        logic rv;
        logic rc;
        logic rdy;
        logic lost;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int rcpu_high;
        int t24, t12, t6, t6n, p24, p12, p6, p6n;
        int lhold, shold;
        logic lv, sv;

        // Bring-up, 1-cycle soft reset, then lock loss in RUN and re-lock
        tbl.push_back('{18, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{ 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{18, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{ 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{ 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

        do_reset();
        chk("reset_rst_video", rst_video, 1'b1);
        chk("reset_ready", ready, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].ncyc) step(tbl[i].l, tbl[i].s);
            chk($sformatf("tbl%0d_rst_video", i), rst_video, tbl[i].rv);
            chk($sformatf("tbl%0d_rst_cpu", i), rst_cpu, tbl[i].rc);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_lock_lost", i), lock_lost, tbl[i].lost);
        end

        // Enable periods and ce_6m / ce_6m_n separation in RUN
        t24 = -1; t12 = -1; t6 = -1; t6n = -1;
        p24 = 0; p12 = 0; p6 = 0; p6n = 0;
        for (int c = 0; c < 64; c++) begin
            step(1'b1, 1'b0);
            if (ce_24m) begin if (t24 >= 0) p24 = c - t24; t24 = c; end
            if (ce_12m) begin if (t12 >= 0) p12 = c - t12; t12 = c; end
            if (ce_6m)  begin if (t6 >= 0)  p6  = c - t6;  t6  = c; end
            if (ce_6m_n) begin if (t6n >= 0) p6n = c - t6n; t6n = c; end
        end
        chk_int("ce_24m_period", p24, 4);
        chk_int("ce_12m_period", p12, 8);
        chk_int("ce_6m_period", p6, 16);
        chk_int("ce_6m_n_period", p6n, 16);
        chk_int("ce_6m_vs_6m_n_offset", (t6 - t6n + 16) % 16, 8);

        // Soft reset held for 20 cycles stretches the CPU reset to match
        rcpu_high = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, (c < 20));
            if (rst_cpu) rcpu_high++;
        end
        chk_int("soft20_rst_cpu_width", rcpu_high, 20);
        chk("soft20_ready_after", ready, 1'b1);

        // Lock glitch during STABLE restarts the stability count
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step(!(e >= 10 && e <= 12), 1'b0);
            if (e == 30) chk("glitch_rv_before", rst_video, 1'b1);
            if (e == 31) chk("glitch_rv_after", rst_video, 1'b0);
        end
        chk("glitch_lock_lost", lock_lost, 1'b0);

        // Asynchronous reset in the middle of RELEASE
        do_reset();
        repeat (22) step(1'b1, 1'b0);
        chk("midrel_ce_24m_live", ce_24m, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_video", rst_video, 1'b1);
        chk("async_rst_cpu", rst_cpu, 1'b1);
        chk("async_ce_24m", ce_24m, 1'b0);
        chk("async_ce_12m", ce_12m, 1'b0);
        chk("async_ce_6m", ce_6m, 1'b0);
        chk("async_ce_6m_n", ce_6m_n, 1'b0);
        chk("async_ready", ready, 1'b0);
        chk("async_lock_lost", lock_lost, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (18) step(1'b1, 1'b0);
        chk("restart_rv_before", rst_video, 1'b1);
        step(1'b1, 1'b0);
        chk("restart_rv_after", rst_video, 1'b0);

        // Randomized lock drops and soft-reset requests against the model
        do_reset();
        lhold = 0;
        shold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (lhold > 0) begin
                lhold--;
                lv = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                lhold = int'($urandom_range(0, 4));
                lv = 1'b0;
            end else begin
                lv = 1'b1;
            end
            if (shold > 0) begin
                shold--;
                sv = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
                shold = int'($urandom_range(0, 9));
                sv = 1'b1;
            end else begin
                sv = 1'b0;
            end
            step(lv, sv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
